// File: rtl/cas_player_pkg.sv
// Shared types and helpers for the cassette playback engine.
package cas_player_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SPINUP,
    FETCH,
    LATCH,
    HI,
    LO,
    END
  } state_t;

  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned bit_hz);
    return clk_hz / (2 * bit_hz);
  endfunction

endpackage

// File: rtl/cas_bit_timer.sv
// Loadable down-counter for FSK half periods; freezes while run is low.
module cas_bit_timer
  import cas_player_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/cas_player.sv
// cas_player: streams a tape image from a byte buffer as CoCo FSK cassette audio.
// Optional motor spin-up silence before the first fetch: define CAS_PLAYER_MOTOR_DLY_EN.
module cas_player
  import cas_player_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BIT0_HZ      = 1200,
  parameter int unsigned BIT1_HZ      = 2400,
  parameter int unsigned MOTOR_DLY_MS = 100
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EN,
  input  logic              REWIND,
  input  logic              LOAD_BUSY,
  input  logic [ADDR_W:0]   TAPE_LEN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_DATA,
  output logic              DOUT,
  output logic              PLAYING,
  output logic              EOT,
  output logic [ADDR_W:0]   POS
);

  localparam logic [CNT_W-1:0] HP0_M1 = CNT_W'(half_period(CLK_HZ, BIT0_HZ) - 32'd1);
  localparam logic [CNT_W-1:0] HP1_M1 = CNT_W'(half_period(CLK_HZ, BIT1_HZ) - 32'd1);
`ifdef CAS_PLAYER_MOTOR_DLY_EN
  localparam longint unsigned  SPIN_CYC = 64'(MOTOR_DLY_MS) * 64'(CLK_HZ) / 64'd1000;
  localparam logic [CNT_W-1:0] SPIN_M1  = CNT_W'(SPIN_CYC - 64'd1);
`endif

  state_t            state;
  logic [7:0]        shift;
  logic [2:0]        idx;
  logic [7:0]        pf_data;
  logic              pf_valid;
  logic              pf_req;
  logic              pf_ret;
  logic              rd_q;
  logic [ADDR_W:0]   tlen_q;

  logic              restart;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_run;
  logic              tmr_done;

  function automatic logic [CNT_W-1:0] hp_m1(input logic b);
    return b ? HP1_M1 : HP0_M1;
  endfunction

  assign restart = REWIND || LOAD_BUSY;

  // The strobe is gated combinationally so a download starting mid-fetch
  // never lets a read reach the buffer in that same cycle.
  assign MEM_RD = rd_q && !LOAD_BUSY;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HP0_M1;
    tmr_run  = 1'b0;
    unique case (state)
`ifdef CAS_PLAYER_MOTOR_DLY_EN
      IDLE: begin
        if (EN && (POS < TAPE_LEN)) begin
          tmr_load = 1'b1;
          tmr_val  = SPIN_M1;
        end
      end
      SPINUP: tmr_run = EN;
`endif
      LATCH: begin
        tmr_load = 1'b1;
        tmr_val  = hp_m1(MEM_DATA[0]);
      end
      HI: begin
        tmr_run = EN;
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = hp_m1(shift[0]);
        end
      end
      LO: begin
        tmr_run = EN;
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = (idx == 3'd7) ? hp_m1(pf_data[0]) : hp_m1(shift[1]);
        end
      end
      default: ;
    endcase
  end

  cas_bit_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .clear    (restart),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      shift    <= '0;
      idx      <= '0;
      pf_data  <= '0;
      pf_valid <= 1'b0;
      pf_req   <= 1'b0;
      pf_ret   <= 1'b0;
      rd_q     <= 1'b0;
      tlen_q   <= '0;
      MEM_ADDR <= '0;
      DOUT     <= 1'b0;
      PLAYING  <= 1'b0;
      EOT      <= 1'b0;
      POS      <= '0;
    end else if (restart) begin
      state    <= IDLE;
      idx      <= '0;
      pf_valid <= 1'b0;
      pf_req   <= 1'b0;
      pf_ret   <= 1'b0;
      rd_q     <= 1'b0;
      MEM_ADDR <= '0;
      DOUT     <= 1'b0;
      PLAYING  <= 1'b0;
      EOT      <= 1'b0;
      POS      <= '0;
    end else begin
      rd_q    <= 1'b0;
      pf_req  <= 1'b0;
      pf_ret  <= pf_req;
      PLAYING <= 1'b0;
      if (pf_ret) begin
        pf_data  <= MEM_DATA;
        pf_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          tlen_q <= TAPE_LEN;
          if (EN) begin
            if (POS < TAPE_LEN) begin
`ifdef CAS_PLAYER_MOTOR_DLY_EN
              state <= SPINUP;
`else
              state    <= FETCH;
              rd_q     <= 1'b1;
              MEM_ADDR <= POS[ADDR_W-1:0];
`endif
            end else begin
              state <= END;
              EOT   <= 1'b1;
            end
          end
        end
`ifdef CAS_PLAYER_MOTOR_DLY_EN
        SPINUP: begin
          if (!EN) begin
            state <= IDLE;
          end else if (tmr_done) begin
            state    <= FETCH;
            rd_q     <= 1'b1;
            MEM_ADDR <= POS[ADDR_W-1:0];
          end
        end
`endif
        FETCH: state <= LATCH;
        LATCH: begin
          shift   <= MEM_DATA;
          POS     <= POS + (ADDR_W+1)'(1);
          idx     <= '0;
          state   <= HI;
          DOUT    <= 1'b1;
          PLAYING <= EN;
        end
        HI: begin
          PLAYING <= EN;
          // Next byte is read while bit 0 plays so the byte seam has no gap.
          if (EN && (idx == 3'd0) && !pf_valid && !pf_req && !pf_ret && (POS < tlen_q)) begin
            pf_req   <= 1'b1;
            rd_q     <= 1'b1;
            MEM_ADDR <= POS[ADDR_W-1:0];
          end
          if (tmr_done) begin
            state <= LO;
            DOUT  <= 1'b0;
          end
        end
        LO: begin
          PLAYING <= EN;
          if (tmr_done) begin
            if (idx != 3'd7) begin
              shift <= shift >> 1;
              idx   <= idx + 3'd1;
              state <= HI;
              DOUT  <= 1'b1;
            end else begin
              tlen_q   <= TAPE_LEN;
              pf_valid <= 1'b0;
              if (POS < TAPE_LEN) begin
                if (pf_valid) begin
                  shift <= pf_data;
                  POS   <= POS + (ADDR_W+1)'(1);
                  idx   <= '0;
                  state <= HI;
                  DOUT  <= 1'b1;
                end else begin
                  state    <= FETCH;
                  rd_q     <= 1'b1;
                  MEM_ADDR <= POS[ADDR_W-1:0];
                  PLAYING  <= 1'b0;
                end
              end else begin
                state   <= END;
                EOT     <= 1'b1;
                PLAYING <= 1'b0;
              end
            end
          end
        end
        END: begin
          DOUT <= 1'b0;
          EOT  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player at CLK_HZ=24000 (HP0=10, HP1=5); spin-up adds 24 cycles.
module tb_cas_player;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned HP0    = 10;
  localparam int unsigned HP1    = 5;
`ifdef CAS_PLAYER_MOTOR_DLY_EN
  localparam int unsigned SPIN   = 24;
`else
  localparam int unsigned SPIN   = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic              rewind = 1'b0;
  logic              load_busy = 1'b0;
  logic [ADDR_W:0]   tape_len = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        rdata = '0;
  logic              dout;
  logic              playing;
  logic              eot;
  logic [ADDR_W:0]   pos;

  logic [7:0] mem [16];
  logic       trace [$];
  int         rd_cnt = 0;
  int         n_vec = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) rdata <= mem[mem_addr];

  cas_player #(
    .ADDR_W       (ADDR_W),
    .CLK_HZ       (24000),
    .BIT0_HZ      (1200),
    .BIT1_HZ      (2400),
    .MOTOR_DLY_MS (1)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .EN        (en),
    .REWIND    (rewind),
    .LOAD_BUSY (load_busy),
    .TAPE_LEN  (tape_len),
    .MEM_ADDR  (mem_addr),
    .MEM_RD    (mem_rd),
    .MEM_DATA  (rdata),
    .DOUT      (dout),
    .PLAYING   (playing),
    .EOT       (eot),
    .POS       (pos)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_rd) rd_cnt++;
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  // Record DOUT each cycle until EOT rises.
  task automatic capture(input int unsigned budget);
    int unsigned n;
    trace.delete();
    n = 0;
    tick();
    while (!eot && n < budget) begin
      trace.push_back(dout);
      tick();
      n++;
    end
    if (!eot) check("eot_timeout", 0, 1);
  endtask

  task automatic check_runs(input logic [15:0] bytes, input int unsigned nb);
    int unsigned exp_runs [$];
    int unsigned obs_runs [$];
    int          first;
    int unsigned run;
    int unsigned hp;
    logic [7:0]  b;
    for (int unsigned k = 0; k < nb; k++) begin
      b = bytes[k*8 +: 8];
      for (int unsigned i = 0; i < 8; i++) begin
        hp = b[i] ? HP1 : HP0;
        exp_runs.push_back(hp);
        exp_runs.push_back(hp);
      end
    end
    first = -1;
    for (int unsigned i = 0; i < trace.size(); i++)
      if (trace[i] && first < 0) first = int'(i);
    check("dout_latency", 64'(first + 1), 64'(3 + SPIN));
    if (first >= 0) begin
      run = 1;
      for (int unsigned i = int'(first) + 1; i < trace.size(); i++) begin
        if (trace[i] == trace[i-1]) run++;
        else begin
          obs_runs.push_back(run);
          run = 1;
        end
      end
      obs_runs.push_back(run);
    end
    check("n_runs", 64'(obs_runs.size()), 64'(exp_runs.size()));
    for (int unsigned i = 0; i < exp_runs.size() && i < obs_runs.size(); i++)
      check($sformatf("run%0d", i), 64'(obs_runs[i]), 64'(exp_runs[i]));
  endtask

  initial begin
    int rd0;
    int unsigned n;
    int unsigned hi_cnt;
    int unsigned pl_cnt;
    for (int unsigned i = 0; i < 16; i++) mem[i] = 8'h00;

    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_dout", dout, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_playing", playing, 0);
    check("rst_eot", eot, 0);
    check("rst_pos", pos, 0);
    rst_n = 1'b1;
    tick();

    // Single byte 0x01: one short bit then seven long bits.
    mem[0] = 8'h01;
    tape_len = 5'd1;
    rd0 = rd_cnt;
    en = 1'b1;
    capture(1000);
    check_runs(16'h0001, 1);
    check("t1_pos", pos, 1);
    check("t1_dout_end", dout, 0);
    check("t1_rd_pulses", 64'(rd_cnt - rd0), 1);

    // Two bytes back to back through the prefetch path.
    en = 1'b0;
    do_rewind();
    mem[0] = 8'hFF;
    mem[1] = 8'h00;
    tape_len = 5'd2;
    tick();
    rd0 = rd_cnt;
    en = 1'b1;
    capture(1000);
    check_runs(16'h00FF, 2);
    check("t2_pos", pos, 2);
    check("t2_rd_pulses", 64'(rd_cnt - rd0), 2);

    // Rewind at end of tape with the motor still running.
    do_rewind();
    check("rw_eot", eot, 0);
    check("rw_pos", pos, 0);
    check("rw_dout", dout, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mem_rd && n < 100);
    check("rw_rd_latency", 64'(n), 64'(1 + SPIN));
    check("rw_mem_addr", mem_addr, 0);
    load_busy = 1'b1;
    #1;
    check("lb_rd_suppressed", mem_rd, 0);
    tick();
    check("lb_pos", pos, 0);
    check("lb_playing", playing, 0);
    load_busy = 1'b0;
    en = 1'b0;
    tick();

    // Pause three cycles into a 10-cycle high phase.
    mem[0] = 8'h00;
    tape_len = 5'd1;
    tick();
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout && n < 200);
    check("pz_playing", playing, 1);
    tick();
    tick();
    tick();
    en = 1'b0;
    hi_cnt = 0;
    pl_cnt = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      tick();
      if (dout) hi_cnt++;
      if (playing) pl_cnt++;
    end
    check("pz_dout_held", 64'(hi_cnt), 50);
    check("pz_playing_low", 64'(pl_cnt), 0);
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (dout && n < 100);
    check("pz_resume_cycles", 64'(n), 7);
    n = 0;
    while (!eot && n < 400) begin
      tick();
      n++;
    end
    check("pz_eot", eot, 1);
    check("pz_pos", pos, 1);

    // Empty tape goes straight to end without touching the buffer.
    en = 1'b0;
    do_rewind();
    tape_len = '0;
    tick();
    rd0 = rd_cnt;
    en = 1'b1;
    tick();
    check("empty_eot", eot, 1);
    for (int unsigned i = 0; i < 10; i++) tick();
    check("empty_rd_pulses", 64'(rd_cnt - rd0), 0);
    check("empty_pos", pos, 0);

    // Asynchronous reset in the middle of a byte.
    en = 1'b0;
    do_rewind();
    mem[0] = 8'hA5;
    tape_len = 5'd1;
    tick();
    en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout && n < 200);
    tick();
    tick();
    check("pre_rst_pos", pos, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_pos", pos, 0);
    check("arst_playing", playing, 0);
    check("arst_eot", eot, 0);
    check("arst_mem_rd", mem_rd, 0);
    check("arst_mem_addr", mem_addr, 0);
    tick();
    en = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1);
  end

endmodule
